// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter
// Shares one single-port synchronous RAM between two requesters, A and B.
// Each cycle at most one access goes to the RAM. The grant is combinational in
// the request cycle and uses round-robin, or fixed priority to A when
// FIXED_PRIO=1. Read data comes back one cycle after the grant and is tagged
// with a per-requester rvalid.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata  requester A access (held until a_ack)
//   a_ack                    A access issued to the RAM this cycle
//   a_rvalid/a_rdata         A read result (one cycle after the grant)
//   b_*                      the same set for requester B
//   ram_en/ram_we/ram_addr/ram_di  RAM command
//   ram_do                   RAM registered read data
module ram_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [DEPTH_LOG2-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [DEPTH_LOG2-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [DEPTH_LOG2-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_do
);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  prio_e prio_q, prio_d;
  logic  rd_a_q, rd_a_d;
  logic  rd_b_q, rd_b_d;
  logic  gnt_a, gnt_b;

  // Grant decision; requests are ignored entirely while in reset.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst) begin
      if (a_req && b_req) begin
        if (FIXED_PRIO != 0 || prio_q == PRIO_A) begin
          gnt_a = 1'b1;
        end else begin
          gnt_b = 1'b1;
        end
      end else begin
        gnt_a = a_req;
        gnt_b = b_req;
      end
    end
  end

  // Favour the other requester after each grant; hold when idle.
  always_comb begin
    prio_d = prio_q;
    if (FIXED_PRIO == 0) begin
      if (gnt_a) begin
        prio_d = PRIO_B;
      end else if (gnt_b) begin
        prio_d = PRIO_A;
      end
    end
  end

  assign rd_a_d = gnt_a & ~a_we;
  assign rd_b_d = gnt_b & ~b_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= PRIO_A;
      rd_a_q <= 1'b0;
      rd_b_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign a_ack    = gnt_a;
  assign b_ack    = gnt_b;
  assign ram_en   = gnt_a | gnt_b;
  assign ram_we   = (gnt_a & a_we) | (gnt_b & b_we);
  assign ram_addr = gnt_b ? b_addr  : a_addr;
  assign ram_di   = gnt_b ? b_wdata : a_wdata;

  // Masking with rst drops the result of a read granted just before reset.
  assign a_rvalid = rd_a_q & ~rst;
  assign b_rvalid = rd_b_q & ~rst;
  assign a_rdata  = ram_do;
  assign b_rdata  = ram_do;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
module tb_ram_rr_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;

  logic clk;
  logic rst;
  logic ram_init;

  // Index 0: round-robin instance, index 1: fixed-priority instance.
  logic          a_req   [2];
  logic          a_we    [2];
  logic [AW-1:0] a_addr  [2];
  logic [DW-1:0] a_wdata [2];
  logic          a_ack   [2];
  logic          a_rvalid[2];
  logic [DW-1:0] a_rdata [2];
  logic          b_req   [2];
  logic          b_we    [2];
  logic [AW-1:0] b_addr  [2];
  logic [DW-1:0] b_wdata [2];
  logic          b_ack   [2];
  logic          b_rvalid[2];
  logic [DW-1:0] b_rdata [2];
  logic          ram_en  [2];
  logic          ram_we  [2];
  logic [AW-1:0] ram_addr[2];
  logic [DW-1:0] ram_di  [2];
  logic [DW-1:0] ram_do  [2];

  int n_chk;
  int n_fail;

  // Reference model state
  logic [DW-1:0] ref_mem [2][16];
  logic          a_turn  [2];   // A wins the next contention
  logic          pend_v  [2];
  logic          pend_b  [2];   // pending read belongs to B
  logic [DW-1:0] pend_d  [2];
  logic          hold_a  [2];
  logic          hold_b  [2];
  int            wait_a  [2];
  int            wait_b  [2];

  ram_rr_arbiter #(.DATA_WIDTH(DW), .DEPTH_LOG2(AW), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .a_req(a_req[0]), .a_we(a_we[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
    .a_ack(a_ack[0]), .a_rvalid(a_rvalid[0]), .a_rdata(a_rdata[0]),
    .b_req(b_req[0]), .b_we(b_we[0]), .b_addr(b_addr[0]), .b_wdata(b_wdata[0]),
    .b_ack(b_ack[0]), .b_rvalid(b_rvalid[0]), .b_rdata(b_rdata[0]),
    .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
    .ram_di(ram_di[0]), .ram_do(ram_do[0])
  );

  ram_rr_arbiter #(.DATA_WIDTH(DW), .DEPTH_LOG2(AW), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst),
    .a_req(a_req[1]), .a_we(a_we[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
    .a_ack(a_ack[1]), .a_rvalid(a_rvalid[1]), .a_rdata(a_rdata[1]),
    .b_req(b_req[1]), .b_we(b_we[1]), .b_addr(b_addr[1]), .b_wdata(b_wdata[1]),
    .b_ack(b_ack[1]), .b_rvalid(b_rvalid[1]), .b_rdata(b_rdata[1]),
    .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
    .ram_di(ram_di[1]), .ram_do(ram_do[1])
  );

  function automatic logic [DW-1:0] init_val(input int unsigned i);
    if (i == 3) return 8'h5A;
    return 8'((i * 29 + 7) & 255);
  endfunction

  // Behavioural single-port RAM, write-first, one-cycle registered read.
  logic [DW-1:0] mem [2][16];
  for (genvar k = 0; k < 2; k++) begin : g_ram
    always @(posedge clk) begin
      if (ram_init) begin
        for (int i = 0; i < 16; i++) mem[k][i] <= init_val(i);
      end else if (ram_en[k]) begin
        if (ram_we[k]) begin
          mem[k][ram_addr[k]] <= ram_di[k];
          ram_do[k]           <= ram_di[k];
        end else begin
          ram_do[k] <= mem[k][ram_addr[k]];
        end
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare both instances against the model at the sampling point, then
  // advance the model by one clock using the current inputs.
  task automatic model_cycle();
    for (int k = 0; k < 2; k++) begin
      logic ga, gb, ev_a, ev_b;
      ga = 1'b0;
      gb = 1'b0;
      if (!rst) begin
        if (a_req[k] && b_req[k]) begin
          ga = (k == 1) || a_turn[k];
          gb = !ga;
        end else begin
          ga = a_req[k];
          gb = b_req[k];
        end
      end
      ev_a = !rst && pend_v[k] && !pend_b[k];
      ev_b = !rst && pend_v[k] && pend_b[k];
      chk($sformatf("a_ack[%0d]", k), 32'(a_ack[k]), 32'(ga));
      chk($sformatf("b_ack[%0d]", k), 32'(b_ack[k]), 32'(gb));
      chk($sformatf("ram_en[%0d]", k), 32'(ram_en[k]), 32'(ga | gb));
      chk($sformatf("ram_we[%0d]", k), 32'(ram_we[k]),
          32'((ga & a_we[k]) | (gb & b_we[k])));
      if (ga || gb) begin
        chk($sformatf("ram_addr[%0d]", k), 32'(ram_addr[k]), 32'(ga ? a_addr[k] : b_addr[k]));
        chk($sformatf("ram_di[%0d]", k), 32'(ram_di[k]), 32'(ga ? a_wdata[k] : b_wdata[k]));
      end
      chk($sformatf("a_rvalid[%0d]", k), 32'(a_rvalid[k]), 32'(ev_a));
      chk($sformatf("b_rvalid[%0d]", k), 32'(b_rvalid[k]), 32'(ev_b));
      if (ev_a) chk($sformatf("a_rdata[%0d]", k), 32'(a_rdata[k]), 32'(pend_d[k]));
      if (ev_b) chk($sformatf("b_rdata[%0d]", k), 32'(b_rdata[k]), 32'(pend_d[k]));

      if (k == 0 && !rst) begin
        wait_a[k] = (a_req[k] && !a_ack[k]) ? wait_a[k] + 1 : 0;
        wait_b[k] = (b_req[k] && !b_ack[k]) ? wait_b[k] + 1 : 0;
        if (a_req[k] && b_req[k]) begin
          chk("rr_wait_a", 32'(wait_a[k] <= 1), 32'd1);
          chk("rr_wait_b", 32'(wait_b[k] <= 1), 32'd1);
        end
      end

      hold_a[k] = a_req[k] && !ga;
      hold_b[k] = b_req[k] && !gb;
      pend_v[k] = 1'b0;
      if (rst) begin
        a_turn[k] = 1'b1;
      end else if (ga) begin
        if (a_we[k]) ref_mem[k][a_addr[k]] = a_wdata[k];
        else begin
          pend_v[k] = 1'b1; pend_b[k] = 1'b0; pend_d[k] = ref_mem[k][a_addr[k]];
        end
        a_turn[k] = 1'b0;
      end else if (gb) begin
        if (b_we[k]) ref_mem[k][b_addr[k]] = b_wdata[k];
        else begin
          pend_v[k] = 1'b1; pend_b[k] = 1'b1; pend_d[k] = ref_mem[k][b_addr[k]];
        end
        a_turn[k] = 1'b1;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  task automatic set_a(input int k, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    a_req[k] = req; a_we[k] = we; a_addr[k] = addr; a_wdata[k] = wd;
  endtask

  task automatic set_b(input int k, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    b_req[k] = req; b_we[k] = we; b_addr[k] = addr; b_wdata[k] = wd;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst      = 1'b1;
    ram_init = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_a(k, 1'b0, 1'b0, '0, '0);
      set_b(k, 1'b0, 1'b0, '0, '0);
      a_turn[k] = 1'b1; pend_v[k] = 1'b0; pend_b[k] = 1'b0; pend_d[k] = '0;
      hold_a[k] = 1'b0; hold_b[k] = 1'b0; wait_a[k] = 0; wait_b[k] = 0;
      for (int i = 0; i < 16; i++) ref_mem[k][i] = init_val(i);
    end
    @(posedge clk);
    #1;
    ram_init = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;

    // Both requesters hold reads: alternation vs. A always winning.
    for (int k = 0; k < 2; k++) begin
      set_a(k, 1'b1, 1'b0, 4'd1, '0);
      set_b(k, 1'b1, 1'b0, 4'd2, '0);
    end
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("rr_alt_a", 32'(a_ack[0]), 32'(i % 2 == 0));
      chk("rr_alt_b", 32'(b_ack[0]), 32'(i % 2 == 1));
      chk("fp_a", 32'(a_ack[1]), 32'd1);
      chk("fp_b", 32'(b_ack[1]), 32'd0);
      if (i > 0) chk("rr_rv_owner", 32'(a_rvalid[0]), 32'(i % 2 == 1));
      advance();
    end
    for (int k = 0; k < 2; k++) a_req[k] = 1'b0;
    settle();
    chk("fp_b_after_drop", 32'(b_ack[1]), 32'd1);
    advance();
    for (int k = 0; k < 2; k++) b_req[k] = 1'b0;
    cyc();

    // Lone A read of address 3.
    set_a(0, 1'b1, 1'b0, 4'd3, '0);
    settle();
    chk("t1_ack", 32'(a_ack[0]), 32'd1);
    advance();
    a_req[0] = 1'b0;
    settle();
    chk("t1_rvalid", 32'(a_rvalid[0]), 32'd1);
    chk("t1_rdata", 32'(a_rdata[0]), 32'h5A);
    chk("t1_b_rvalid", 32'(b_rvalid[0]), 32'd0);
    advance();

    // A writes 0xC3 to 7, B reads 7 next cycle.
    set_a(0, 1'b1, 1'b1, 4'd7, 8'hC3);
    settle();
    chk("t4_wr_ack", 32'(a_ack[0]), 32'd1);
    advance();
    a_req[0] = 1'b0;
    set_b(0, 1'b1, 1'b0, 4'd7, '0);
    settle();
    chk("t4_rd_ack", 32'(b_ack[0]), 32'd1);
    advance();
    b_req[0] = 1'b0;
    settle();
    chk("t4_rvalid", 32'(b_rvalid[0]), 32'd1);
    chk("t4_rdata", 32'(b_rdata[0]), 32'hC3);
    advance();

    // Read granted to A, then reset in the following cycle.
    set_a(0, 1'b1, 1'b0, 4'd5, '0);
    settle();
    chk("t5_ack", 32'(a_ack[0]), 32'd1);
    advance();
    a_req[0] = 1'b0;
    rst = 1'b1;
    settle();
    chk("t5_rvalid_rst", 32'(a_rvalid[0]), 32'd0);
    chk("t5_en_rst", 32'(ram_en[0]), 32'd0);
    advance();
    rst = 1'b0;
    settle();
    chk("t5_rvalid_post", 32'(a_rvalid[0]), 32'd0);
    advance();
    set_a(0, 1'b1, 1'b0, 4'd1, '0);
    set_b(0, 1'b1, 1'b0, 4'd2, '0);
    settle();
    chk("t5_first_a", 32'(a_ack[0]), 32'd1);
    chk("t5_first_b", 32'(b_ack[0]), 32'd0);
    advance();
    a_req[0] = 1'b0;
    cyc();
    b_req[0] = 1'b0;
    cyc();

    // Random traffic; requests stay stable until acknowledged.
    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!hold_a[k])
          set_a(k, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 7)), 8'($urandom));
        if (!hold_b[k])
          set_b(k, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 7)), 8'($urandom));
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
